// File: rtl/riscv_memory_arbiter.sv
// Shares one memory port between the I-cache, D-cache and debug requesters.
// Grants are fixed-priority with a D starvation override and an X lock; an owner FIFO routes each response.
module riscv_memory_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned WAIT_WIDTH      = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [31:0]                              i_address,
  input  logic                                     i_read,
  output logic                                     i_grant,
  output logic                                     i_ready,
  input  logic [31:0]                              d_address,
  input  logic                                     d_read,
  input  logic                                     d_write,
  input  logic [31:0]                              d_out,
  output logic                                     d_grant,
  output logic                                     d_ready,
  input  logic [31:0]                              x_address,
  input  logic                                     x_read,
  input  logic                                     x_write,
  input  logic [31:0]                              x_out,
  input  logic                                     x_lock,
  output logic                                     x_grant,
  output logic                                     x_ready,
  output logic [31:0]                              memory_address,
  output logic                                     memory_read,
  output logic                                     memory_write,
  output logic [31:0]                              memory_out,
  input  logic                                     memory_busy,
  input  logic                                     memory_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     protocol_error
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    OWN_I    = 2'd0,
    OWN_D    = 2'd1,
    OWN_X    = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  owner_t                fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [WAIT_WIDTH-1:0] d_wait;
  owner_t                winner;
  owner_t                head;
  logic                  i_req, d_req, x_req;
  logic                  space, starve, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign x_req = x_read | x_write;

  // A full FIFO still accepts a push when the head pops in the same cycle.
  assign pop    = memory_ready && (count != '0);
  assign space  = !memory_busy && ((count < CW'(MAX_OUTSTANDING)) || memory_ready);
  assign starve = (STARVE_LIMIT != 0) && (d_wait >= WAIT_WIDTH'(STARVE_LIMIT));

  always_comb begin
    winner = OWN_NONE;
    if (!reset && space) begin
      if (x_lock) begin
        if (x_req) winner = OWN_X;
      end else if (starve && d_req) winner = OWN_D;
      else if (i_req)               winner = OWN_I;
      else if (d_req)               winner = OWN_D;
      else if (x_req)               winner = OWN_X;
    end
  end

  assign push = (winner != OWN_NONE);

  always_comb begin
    i_grant        = 1'b0;
    d_grant        = 1'b0;
    x_grant        = 1'b0;
    memory_address = '0;
    memory_read    = 1'b0;
    memory_write   = 1'b0;
    memory_out     = '0;
    case (winner)
      OWN_I: begin
        i_grant        = 1'b1;
        memory_address = i_address;
        memory_read    = 1'b1;
      end
      OWN_D: begin
        d_grant        = 1'b1;
        memory_address = d_address;
        memory_write   = d_write;
        memory_read    = d_read & ~d_write;
        memory_out     = d_out;
      end
      OWN_X: begin
        x_grant        = 1'b1;
        memory_address = x_address;
        memory_write   = x_write;
        memory_read    = x_read & ~x_write;
        memory_out     = x_out;
      end
      default: ;
    endcase
  end

  assign head    = fifo_mem[rd_ptr];
  assign i_ready = pop && (head == OWN_I);
  assign d_ready = pop && (head == OWN_D);
  assign x_ready = pop && (head == OWN_X);
  assign outstanding = count;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      d_wait         <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (d_req && !d_grant) begin
        if (d_wait != '1) d_wait <= d_wait + 1'b1;
      end else begin
        d_wait <= '0;
      end
      if (memory_ready && (count == '0)) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Scoreboard bench for riscv_memory_arbiter: directed stimulus queues expected grants and
// responses; a negedge monitor pops and compares them whenever the DUT issues or answers.
module tb_riscv_memory_arbiter;

  localparam logic [1:0] OI = 2'd0, OD = 2'd1, OX = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i_address, d_address, d_out, x_address, x_out;
  logic        i_read, d_read, d_write, x_read, x_write, x_lock;
  logic        i_grant, i_ready, d_grant, d_ready, x_grant, x_ready;
  logic [31:0] memory_address, memory_out;
  logic        memory_read, memory_write, memory_busy, memory_ready;
  logic [2:0]  outstanding;
  logic        protocol_error;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] data;
  } gexp_t;

  gexp_t      gq[$];
  logic [1:0] rq[$];
  int         checks = 0;
  int         errors = 0;

  riscv_memory_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8), .WAIT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_grant(i_grant), .i_ready(i_ready),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_out(d_out),
    .d_grant(d_grant), .d_ready(d_ready),
    .x_address(x_address), .x_read(x_read), .x_write(x_write), .x_out(x_out),
    .x_lock(x_lock), .x_grant(x_grant), .x_ready(x_ready),
    .memory_address(memory_address), .memory_read(memory_read), .memory_write(memory_write),
    .memory_out(memory_out), .memory_busy(memory_busy), .memory_ready(memory_ready),
    .outstanding(outstanding), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] who);
    case (who)
      OI:      return 3'b001;
      OD:      return 3'b010;
      OX:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic exp_grant(input logic [1:0] who, input logic [31:0] addr, input logic rd,
                           input logic wr, input logic [31:0] data);
    gexp_t e;
    e.who = who; e.addr = addr; e.rd = rd; e.wr = wr; e.data = data;
    gq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_flags"}, {i_grant, d_grant, x_grant, i_ready, d_ready, x_ready,
                           memory_read, memory_write}, 0);
    chk({name, "_bus"}, {memory_address, memory_out}, 0);
  endtask

  // Monitor: every grant or response the DUT presents must match the head of its queue.
  initial begin
    gexp_t e;
    logic [1:0] w;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ({x_grant, d_grant, i_grant} != 3'b000) begin
          if (gq.size() == 0) chk("unexpected_grant", {x_grant, d_grant, i_grant}, 0);
          else begin
            e = gq.pop_front();
            chk("grant_who", {x_grant, d_grant, i_grant}, onehot(e.who));
            chk("mem_addr", memory_address, e.addr);
            chk("mem_rw", {memory_read, memory_write}, {e.rd, e.wr});
            chk("mem_out", memory_out, e.data);
          end
        end
        if ({x_ready, d_ready, i_ready} != 3'b000) begin
          if (rq.size() == 0) chk("unexpected_ready", {x_ready, d_ready, i_ready}, 0);
          else begin
            w = rq.pop_front();
            chk("ready_who", {x_ready, d_ready, i_ready}, onehot(w));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_address = '0; d_address = '0; d_out = '0; x_address = '0; x_out = '0;
    i_read = 1'b1; d_read = 1'b0; d_write = 1'b1; x_read = 1'b1; x_write = 1'b0;
    x_lock = 1'b0; memory_busy = 1'b0; memory_ready = 1'b1;
    #2;
    chk_idle("reset_outputs");
    chk("reset_outstanding", outstanding, 0);
    chk("reset_error", protocol_error, 0);
    i_read = 1'b0; d_write = 1'b0; x_read = 1'b0; memory_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Single I read, blocked by busy for one cycle, latency 1.
    cyc(); i_read = 1'b1; i_address = 32'h100; memory_busy = 1'b1;
    #1 chk("busy_blocks", i_grant, 0);
    cyc(); memory_busy = 1'b0; exp_grant(OI, 32'h100, 1'b1, 1'b0, 32'h0);
    cyc(); chk("i_only_outstanding1", outstanding, 1);
    i_read = 1'b0; memory_ready = 1'b1; rq.push_back(OI);
    cyc(); memory_ready = 1'b0; chk("i_only_outstanding0", outstanding, 0);

    // Contention: D wins on its 9th waiting cycle.
    for (int c = 0; c <= 8; c++) begin
      cyc();
      i_read = 1'b1; i_address = 32'h100; d_read = 1'b1; d_address = 32'h200;
      memory_ready = (c > 0);
      if (c > 0) rq.push_back(OI);
      if (c == 8) exp_grant(OD, 32'h200, 1'b1, 1'b0, 32'h0);
      else        exp_grant(OI, 32'h100, 1'b1, 1'b0, 32'h0);
    end
    cyc(); i_read = 1'b0; d_read = 1'b0; memory_ready = 1'b1; rq.push_back(OD);
    cyc(); memory_ready = 1'b0;
    chk("starve_outstanding0", outstanding, 0);
    chk("starve_wait_cleared", dut.d_wait, 0);

    // Full FIFO: four grants, stall, then pop and push in one cycle.
    for (int c = 0; c < 4; c++) begin
      cyc(); i_read = 1'b1; i_address = 32'h1000 + 32'(c) * 4;
      exp_grant(OI, i_address, 1'b1, 1'b0, 32'h0);
    end
    cyc(); chk("full_outstanding", outstanding, 4);
    #1 chk("full_blocks", i_grant, 0);
    cyc(); memory_ready = 1'b1; rq.push_back(OI); i_address = 32'h1010;
    exp_grant(OI, 32'h1010, 1'b1, 1'b0, 32'h0);
    cyc(); i_read = 1'b0; memory_ready = 1'b0;
    chk("full_push_pop", outstanding, 4);
    for (int c = 0; c < 4; c++) begin
      cyc(); memory_ready = 1'b1; rq.push_back(OI);
    end
    cyc(); memory_ready = 1'b0; chk("full_drained", outstanding, 0);

    // Ordering, including a D read+write that must issue as a write.
    cyc(); i_read = 1'b1; i_address = 32'h400; exp_grant(OI, 32'h400, 1'b1, 1'b0, 32'h0);
    cyc(); i_read = 1'b0; d_read = 1'b1; d_write = 1'b1; d_address = 32'h300;
    d_out = 32'hDEADBEEF; exp_grant(OD, 32'h300, 1'b0, 1'b1, 32'hDEADBEEF);
    cyc(); d_read = 1'b0; d_write = 1'b0; d_out = '0; x_read = 1'b1; x_address = 32'h500;
    exp_grant(OX, 32'h500, 1'b1, 1'b0, 32'h0);
    cyc(); x_read = 1'b0; chk("order_outstanding3", outstanding, 3);
    memory_ready = 1'b1; rq.push_back(OI);
    cyc(); rq.push_back(OD);
    cyc(); rq.push_back(OX);
    cyc(); memory_ready = 1'b0; chk("order_outstanding0", outstanding, 0);

    // Lock: only X may win; with X idle nobody wins and D keeps counting.
    cyc(); x_lock = 1'b1; i_read = 1'b1; i_address = 32'h700; d_read = 1'b1;
    d_address = 32'h800; x_write = 1'b1; x_address = 32'h600; x_out = 32'hCAFEF00D;
    exp_grant(OX, 32'h600, 1'b0, 1'b1, 32'hCAFEF00D);
    cyc(); x_write = 1'b0; x_out = '0; memory_ready = 1'b1; rq.push_back(OX);
    #1 chk("lock_idle1", {x_grant, d_grant, i_grant}, 0);
    cyc(); memory_ready = 1'b0; chk("lock_wait_count", dut.d_wait, 2);
    #1 chk("lock_idle2", {x_grant, d_grant, i_grant}, 0);
    cyc(); x_lock = 1'b0; i_read = 1'b0; d_read = 1'b0;
    cyc(); chk("lock_wait_cleared", dut.d_wait, 0);
    chk("lock_outstanding0", outstanding, 0);

    // Reset mid-flight discards commands; stale responses raise a sticky error.
    cyc(); i_read = 1'b1; i_address = 32'h900; exp_grant(OI, 32'h900, 1'b1, 1'b0, 32'h0);
    cyc(); i_address = 32'h904; exp_grant(OI, 32'h904, 1'b1, 1'b0, 32'h0);
    cyc(); i_read = 1'b0; chk("pre_reset_outstanding", outstanding, 2);
    #1 reset = 1'b1; i_read = 1'b1;
    #1 chk("async_reset_outstanding", outstanding, 0);
    chk_idle("async_reset_outputs");
    i_read = 1'b0;
    cyc(); cyc(); reset = 1'b0;
    cyc(); memory_ready = 1'b1;
    #1 chk("stale_ready", {x_ready, d_ready, i_ready}, 0);
    cyc(); memory_ready = 1'b0; chk("error_set", protocol_error, 1);
    cyc(); cyc(); chk("error_sticky", protocol_error, 1);
    reset = 1'b1;
    #1 chk("error_cleared", protocol_error, 0);
    cyc(); reset = 1'b0;

    for (int k = 0; k < 20 && (gq.size() + rq.size()) != 0; k++) cyc();
    chk("scoreboard_drain", gq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
